// File: rtl/fetch_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared widths, default constants and the IF/ID record type
//               used by the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_BUS-1:0]      NOP_INST_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [INST_BUS-1:0]      ZERO_WORD        = 32'h0000_0000;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [INST_ADDR_BUS-1:0] pc;
      logic [INST_BUS-1:0]      inst;
      logic                     valid;
      logic                     adel;
   } ifid_t;

   // Empty slot handed to decode on a stall bubble or flush
   function automatic ifid_t ifid_bubble(input logic [INST_BUS-1:0] nop);
      ifid_t b;
      b.pc    = ZERO_WORD;
      b.inst  = nop;
      b.valid = 1'b0;
      b.adel  = 1'b0;
      return b;
   endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bundle of all non-clock signals of the fetch stage.
//               master : the fetch stage (drives ROM ce/addr and IF/ID outputs)
//               slave  : the surroundings (hazard unit, ID redirect, ROM)
//   stall_if/stall_id/flush/new_pc/branch_flag/branch_target : control in
//   inst_ce/inst_addr/inst_data                              : ROM port
//   id_pc/id_inst/id_valid/id_adel                           : to decode
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic                     stall_if;
   logic                     stall_id;
   logic                     flush;
   logic [INST_ADDR_BUS-1:0] new_pc;
   logic                     branch_flag;
   logic [INST_ADDR_BUS-1:0] branch_target;
   logic                     inst_ce;
   logic [INST_ADDR_BUS-1:0] inst_addr;
   logic [INST_BUS-1:0]      inst_data;
   logic [INST_ADDR_BUS-1:0] id_pc;
   logic [INST_BUS-1:0]      id_inst;
   logic                     id_valid;
   logic                     id_adel;

   modport master (
      input  stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst_data,
      output inst_ce, inst_addr, id_pc, id_inst, id_valid, id_adel
   );

   modport slave (
      output stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst_data,
      input  inst_ce, inst_addr, id_pc, id_inst, id_valid, id_adel
   );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pc_reg
// Description : Program counter, ROM chip enable and next-PC selection.
//   clk, rst              : clock, asynchronous active-high reset
//   flush, new_pc         : exception/eret redirect (highest priority)
//   stall_if              : hold the PC
//   branch_flag/_target   : taken branch/jump redirect from ID
//   inst_ce               : ROM chip enable (0 only in the edge after reset)
//   pc                    : current fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_pc_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [INST_ADDR_BUS-1:0] new_pc,
   input  logic                     stall_if,
   input  logic                     branch_flag,
   input  logic [INST_ADDR_BUS-1:0] branch_target,
   output logic                     inst_ce,
   output logic [INST_ADDR_BUS-1:0] pc
);

   logic                     ce_q, ce_d;
   logic [INST_ADDR_BUS-1:0] pc_q, pc_d;

   always_comb begin
      // Once armed, the enable never drops again until the next reset
      ce_d = 1'b1;
      pc_d = pc_q;
      if (!ce_q) begin
         // First edge out of reset: RESET_PC is the first address fetched
         pc_d = RESET_PC;
      end else if (flush) begin
         pc_d = new_pc;
      end else if (stall_if) begin
         // A branch presented during a stall is dropped; ID re-presents it
         pc_d = pc_q;
      end else if (branch_flag) begin
         pc_d = branch_target;
      end else begin
         // Plain 32-bit increment; 0xFFFF_FFFC wraps silently to zero
         pc_d = pc_q + INST_ADDR_BUS'(4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_q <= 1'b0;
         pc_q <= RESET_PC;
      end else begin
         ce_q <= ce_d;
         pc_q <= pc_d;
      end
   end

   assign inst_ce = ce_q;
   assign pc      = pc_q;

endmodule : fetch_stage_pc_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction-fetch stage. Presents the PC to a
//               combinational instruction ROM and captures the returned word
//               into the IF/ID register, handling stalls, branch redirect
//               (with delay slot), flush and misaligned-fetch marking.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master (control in, ROM port, IF/ID out)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [INST_BUS-1:0]      NOP_INST = NOP_INST_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   logic                     inst_ce;
   logic [INST_ADDR_BUS-1:0] pc;
   logic                     misaligned;
   ifid_t                    ifid_q, ifid_d;

   fetch_stage_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst           (rst),
      .flush         (bus.flush),
      .new_pc        (bus.new_pc),
      .stall_if      (bus.stall_if),
      .branch_flag   (bus.branch_flag),
      .branch_target (bus.branch_target),
      .inst_ce       (inst_ce),
      .pc            (pc)
   );

   // No gating by ce: the ROM itself returns zero while disabled
   assign bus.inst_ce   = inst_ce;
   assign bus.inst_addr = pc;

   assign misaligned = |pc[1:0];

   always_comb begin
      ifid_d = ifid_q;
      if (!inst_ce || bus.flush) begin
         ifid_d = ifid_bubble(NOP_INST);
      end else if (bus.stall_id) begin
         ifid_d = ifid_q;
      end else if (bus.stall_if) begin
         // Decode moves on but fetch is held: hand decode an empty slot
         ifid_d = ifid_bubble(NOP_INST);
      end else begin
         ifid_d.pc    = pc;
         // A misaligned word is never executed; decode only sees the AdEL mark
         ifid_d.inst  = misaligned ? NOP_INST : bus.inst_data;
         ifid_d.valid = 1'b1;
         ifid_d.adel  = misaligned;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_q <= ifid_bubble(NOP_INST);
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign bus.id_pc    = ifid_q.pc;
   assign bus.id_inst  = ifid_q.inst;
   assign bus.id_valid = ifid_q.valid;
   assign bus.id_adel  = ifid_q.adel;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Stimulus pushes the
//               expected post-edge view into a queue; a monitor pops and
//               compares after every rising edge (and after async resets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   typedef struct packed {
      logic        ce;
      logic [31:0] addr;
      logic [31:0] id_pc;
      logic [31:0] id_inst;
      logic        id_valid;
      logic        id_adel;
   } view_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction ROM: word n holds 0x2400_0000 + (n+1)*0x0001_0001
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h2400_0000 + ((a >> 2) + 32'd1) * 32'h0001_0001;
   endfunction

   assign bus.inst_data = bus.inst_ce ? rom_word(bus.inst_addr) : 32'h0;

   // ---------------- reference model ----------------
   logic        m_ce;
   logic [31:0] m_pc;
   view_t       m_id;     // only id_* fields used
   view_t       exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   event        chk_now;

   function automatic view_t bubble_view();
      view_t v;
      v = '0;
      return v;
   endfunction

   function automatic view_t current_view();
      view_t v;
      v = m_id;
      v.ce   = m_ce;
      v.addr = m_pc;
      return v;
   endfunction

   task automatic model_reset();
      m_ce = 1'b0;
      m_pc = 32'h0;
      m_id = bubble_view();
   endtask

   // What happens at one rising edge, expressed as the fate of the
   // instruction currently being fetched and where fetch goes next.
   task automatic model_edge(input logic sif, sid, fl, input logic [31:0] npc,
                             input logic br, input logic [31:0] bt);
      view_t fetched;
      if (!m_ce) begin
         m_ce = 1'b1;
         m_id = bubble_view();
         return;
      end
      fetched = '0;
      fetched.id_pc    = m_pc;
      fetched.id_valid = 1'b1;
      fetched.id_adel  = (m_pc % 4) != 0;
      fetched.id_inst  = fetched.id_adel ? 32'h0 : rom_word(m_pc);
      if (fl)        m_id = bubble_view();
      else if (sid)  ;                        // decode holds what it has
      else if (sif)  m_id = bubble_view();
      else           m_id = fetched;
      if (fl)        m_pc = npc;
      else if (sif)  ;
      else if (br)   m_pc = bt;
      else           m_pc = m_pc + 32'd4;
   endtask

   task automatic drive(input logic sif, sid, fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] bt);
      @(negedge clk);
      rst               = 1'b0;
      bus.stall_if      = sif;
      bus.stall_id      = sid;
      bus.flush         = fl;
      bus.new_pc        = npc;
      bus.branch_flag   = br;
      bus.branch_target = bt;
      model_edge(sif, sid, fl, npc, br, bt);
      exp_q.push_back(current_view());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   // Asynchronous reset in the middle of a cycle, checked immediately,
   // then held across one rising edge.
   task automatic mid_reset();
      @(negedge clk);
      bus.stall_if = 1'b1; bus.stall_id = 1'b1; bus.flush = 1'b1;
      #2 rst = 1'b1;
      model_reset();
      exp_q.push_back(current_view());
      -> chk_now;
      #2 exp_q.push_back(current_view());
   endtask

   task automatic run_until_pc(input logic [31:0] target);
      for (int i = 0; i < 40 && m_pc != target; i++) idle(1);
   endtask

   // ---------------- monitor ----------------
   initial begin
      view_t e, a;
      forever begin
         @(posedge clk or chk_now);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.ce = bus.inst_ce;       a.addr = bus.inst_addr;
            a.id_pc = bus.id_pc;      a.id_inst = bus.id_inst;
            a.id_valid = bus.id_valid; a.id_adel = bus.id_adel;
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL vec%0d @%0t: got ce=%b addr=%h id_pc=%h id_inst=%h valid=%b adel=%b ; expected ce=%b addr=%h id_pc=%h id_inst=%h valid=%b adel=%b",
                        n_vec, $time, a.ce, a.addr, a.id_pc, a.id_inst, a.id_valid, a.id_adel,
                        e.ce, e.addr, e.id_pc, e.id_inst, e.id_valid, e.id_adel);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] bt, npc;
      bus.stall_if = 0; bus.stall_id = 0; bus.flush = 0;
      bus.new_pc = 0; bus.branch_flag = 0; bus.branch_target = 0;
      model_reset();
      #2;
      exp_q.push_back(current_view());
      -> chk_now;

      // 1: reset release, sequential fetch
      idle(5);
      // 2: full stall for three cycles at pc 0x10
      run_until_pc(32'h10);
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 32'h0, 0, 32'h0);
      idle(2);
      // 3: fetch-only stall -> one bubble
      drive(1, 0, 0, 32'h0, 0, 32'h0);
      idle(2);
      // 4: branch to 0x40 at pc 0x0C with delay slot
      drive(0, 0, 1, 32'h08, 0, 32'h0);
      run_until_pc(32'h0C);
      drive(0, 0, 0, 32'h0, 1, 32'h40);
      idle(3);
      // 5: flush beats stall and branch
      drive(1, 0, 1, 32'h380, 1, 32'h40);
      idle(3);
      // 6: misaligned target, PC wrap, mid-run reset
      drive(0, 0, 0, 32'h0, 1, 32'h42);
      idle(3);
      drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFF8);
      idle(3);
      mid_reset();
      idle(4);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            mid_reset();
         end else begin
            bt  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) bt = bt + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFF0;
            npc = ($urandom_range(0, 1) == 0) ? 32'h380 : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 5, npc, $urandom_range(0, 99) < 15, bt);
         end
      end
      idle(2);

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expected views left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_stage
`default_nettype wire
